// File: rtl/bcd_seq_pkg.sv
// Shared types, widths and digit-weight constants for the BCD weight sequencer.
package bcd_seq_pkg;

    localparam int unsigned DIGIT_W    = 4;
    localparam int unsigned MAX_DIGITS = 4;
    localparam int unsigned SHADOW_W   = DIGIT_W * MAX_DIGITS;
    localparam int unsigned POS_W      = 2;
    localparam int unsigned WEIGHT_W   = 11;
    localparam int unsigned PROD_W     = DIGIT_W + WEIGHT_W;
    localparam int unsigned VALUE_W    = 14;

    localparam logic [WEIGHT_W-1:0] WEIGHT_1    = 11'd1;
    localparam logic [WEIGHT_W-1:0] WEIGHT_10   = 11'd10;
    localparam logic [WEIGHT_W-1:0] WEIGHT_100  = 11'd100;
    localparam logic [WEIGHT_W-1:0] WEIGHT_1000 = 11'd1000;

    typedef enum logic {
        IDLE = 1'b0,
        ACC  = 1'b1
    } state_e;

    // Decimal weight of a digit position (0 = ones).
    function automatic logic [WEIGHT_W-1:0] digit_weight(input logic [POS_W-1:0] pos);
        logic [WEIGHT_W-1:0] w;
        case (pos)
            2'd0:    w = WEIGHT_1;
            2'd1:    w = WEIGHT_10;
            2'd2:    w = WEIGHT_100;
            default: w = WEIGHT_1000;
        endcase
        return w;
    endfunction

endpackage

// File: rtl/digit_weight_mult.sv
// Shared combinational multiplier: one BCD digit times its positional weight.
module digit_weight_mult
    import bcd_seq_pkg::*;
(
    input  logic [DIGIT_W-1:0] digit_i,
    input  logic [POS_W-1:0]   pos_i,
    output logic [PROD_W-1:0]  product_o
);

    assign product_o = PROD_W'(digit_i) * PROD_W'(digit_weight(pos_i));

endmodule

// File: rtl/bcd_weight_sequencer.sv
// Serial BCD-to-binary converter: one shared weight multiplier, MSD first.
// Optional BCD_CHECK_EN adds err_o, flagging any nibble above 9.
module bcd_weight_sequencer
    import bcd_seq_pkg::*;
#(
    parameter int unsigned DIGITS = 4
) (
    input  logic                  clk,
    input  logic                  rst_n,
    input  logic                  start_i,
    input  logic [4*DIGITS-1:0]   digits_in_i,
    output logic                  busy_o,
    output logic                  done_o,
    output logic [VALUE_W-1:0]    value_out_o
`ifdef BCD_CHECK_EN
    ,
    output logic                  err_o
`endif
);

    state_e                state_q, state_d;
    logic [SHADOW_W-1:0]   shadow_q, shadow_d;
    logic [POS_W-1:0]      idx_q, idx_d;
    logic [VALUE_W-1:0]    acc_q, acc_d;
    logic [VALUE_W-1:0]    value_q, value_d;
    logic                  busy_q, busy_d;
    logic                  done_q, done_d;

    logic [DIGIT_W-1:0]    cur_digit;
    logic [PROD_W-1:0]     product;
    logic [VALUE_W-1:0]    sum;

`ifdef BCD_CHECK_EN
    logic                  bad_q, bad_d;
    logic                  err_q, err_d;
    logic                  bad_next;
`endif

    // Shadow is always 4 digits wide; unused upper digits are zero.
    assign cur_digit = shadow_q[{idx_q, 2'b00} +: DIGIT_W];
    assign sum       = acc_q + VALUE_W'(product);

    digit_weight_mult u_mult (
        .digit_i   (cur_digit),
        .pos_i     (idx_q),
        .product_o (product)
    );

    always_comb begin
        state_d  = state_q;
        shadow_d = shadow_q;
        idx_d    = idx_q;
        acc_d    = acc_q;
        value_d  = value_q;
        busy_d   = busy_q;
        done_d   = 1'b0;
`ifdef BCD_CHECK_EN
        bad_d    = bad_q;
        err_d    = err_q;
        bad_next = bad_q | (cur_digit > 4'd9);
`endif
        case (state_q)
            IDLE: begin
                if (start_i) begin
                    shadow_d = SHADOW_W'(digits_in_i);
                    acc_d    = '0;
                    idx_d    = POS_W'(DIGITS - 1);
                    busy_d   = 1'b1;
                    state_d  = ACC;
`ifdef BCD_CHECK_EN
                    bad_d    = 1'b0;
                    err_d    = 1'b0;
`endif
                end
            end
            ACC: begin
                acc_d = sum;
                idx_d = idx_q - 1'b1;
`ifdef BCD_CHECK_EN
                bad_d = bad_next;
`endif
                if (idx_q == '0) begin
                    // Last (ones) digit: publish the result and return to idle.
                    idx_d   = '0;
                    state_d = IDLE;
                    busy_d  = 1'b0;
                    done_d  = 1'b1;
                    value_d = sum;
`ifdef BCD_CHECK_EN
                    err_d   = bad_next;
                    if (bad_next) begin
                        value_d = '0;
                    end
`endif
                end
            end
            default: begin
                state_d = IDLE;
                busy_d  = 1'b0;
            end
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q  <= IDLE;
            shadow_q <= '0;
            idx_q    <= '0;
            acc_q    <= '0;
            value_q  <= '0;
            busy_q   <= 1'b0;
            done_q   <= 1'b0;
`ifdef BCD_CHECK_EN
            bad_q    <= 1'b0;
            err_q    <= 1'b0;
`endif
        end else begin
            state_q  <= state_d;
            shadow_q <= shadow_d;
            idx_q    <= idx_d;
            acc_q    <= acc_d;
            value_q  <= value_d;
            busy_q   <= busy_d;
            done_q   <= done_d;
`ifdef BCD_CHECK_EN
            bad_q    <= bad_d;
            err_q    <= err_d;
`endif
        end
    end

    assign busy_o      = busy_q;
    assign done_o      = done_q;
    assign value_out_o = value_q;
`ifdef BCD_CHECK_EN
    assign err_o       = err_q;
`endif

endmodule

// File: tb/tb_bcd_weight_sequencer.sv
// Directed-vector bench for bcd_weight_sequencer (default DIGITS=4).
module tb_bcd_weight_sequencer;

    logic        clk;
    logic        rst_n;
    logic        start_i;
    logic [15:0] digits_in_i;
    logic        busy_o;
    logic        done_o;
    logic [13:0] value_out_o;
`ifdef BCD_CHECK_EN
    logic        err_o;
`endif

    int n_vec = 0;
    int n_bad = 0;

    bcd_weight_sequencer #(.DIGITS(4)) dut (
        .clk         (clk),
        .rst_n       (rst_n),
        .start_i     (start_i),
        .digits_in_i (digits_in_i),
        .busy_o      (busy_o),
        .done_o      (done_o),
        .value_out_o (value_out_o)
`ifdef BCD_CHECK_EN
        ,
        .err_o       (err_o)
`endif
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic check_val(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_vec++;
        if (got !== exp) begin
            n_bad++;
            $display("FAIL %s: got %0d expected %0d", tag, got, exp);
        end
    endtask

    // One conversion: accept d, present alt afterwards, check latency, busy span and result.
    task automatic convert(input string tag, input logic [15:0] d, input logic [15:0] alt,
                           input logic [13:0] exp, input logic exp_err);
        int cyc;
        int busy_cnt;
        @(negedge clk);
        start_i     = 1'b1;
        digits_in_i = d;
        @(negedge clk);
        start_i     = 1'b0;
        digits_in_i = alt;
        cyc      = 0;
        busy_cnt = 0;
        while (!done_o && cyc < 20) begin
            if (busy_o) busy_cnt++;
            @(negedge clk);
            cyc++;
        end
        check_val({tag, "_latency"}, 32'(cyc), 32'd4);
        check_val({tag, "_busy_cycles"}, 32'(busy_cnt), 32'd4);
        check_val({tag, "_value"}, 32'(value_out_o), 32'(exp));
        check_val({tag, "_busy_at_done"}, 32'(busy_o), 32'd0);
`ifdef BCD_CHECK_EN
        check_val({tag, "_err"}, 32'(err_o), 32'(exp_err));
`else
        if (exp_err) $display("note: %s expects err but check build is off", tag);
`endif
        @(negedge clk);
        check_val({tag, "_done_one_cycle"}, 32'(done_o), 32'd0);
        check_val({tag, "_value_held"}, 32'(value_out_o), 32'(exp));
    endtask

    initial begin
        int k;
        int first_k;
        int second_k;
        logic [13:0] first_v;
        logic [13:0] second_v;
        int done_seen;

        rst_n       = 1'b0;
        start_i     = 1'b0;
        digits_in_i = 16'h0000;
        repeat (2) @(negedge clk);
        check_val("rst_busy", 32'(busy_o), 32'd0);
        check_val("rst_done", 32'(done_o), 32'd0);
        check_val("rst_value", 32'(value_out_o), 32'd0);
`ifdef BCD_CHECK_EN
        check_val("rst_err", 32'(err_o), 32'd0);
`endif
        rst_n = 1'b1;
        @(negedge clk);

        convert("c1234", 16'h1234, 16'h1234, 14'd1234, 1'b0);
        convert("c9999", 16'h9999, 16'h9999, 14'd9999, 1'b0);
        convert("c0000", 16'h0000, 16'h0000, 14'd0, 1'b0);
        convert("c_chg", 16'h1234, 16'h5678, 14'd1234, 1'b0);
        convert("c0907", 16'h0907, 16'h0907, 14'd907, 1'b0);

        // Start held high: inner Starts ignored, results one per 5 cycles.
        @(negedge clk);
        start_i     = 1'b1;
        digits_in_i = 16'h0100;
        @(negedge clk);
        digits_in_i = 16'h0050;
        first_k   = -1;
        second_k  = -1;
        first_v   = '0;
        second_v  = '0;
        done_seen = 0;
        k         = 0;
        while (done_seen < 2 && k < 30) begin
            if (done_o) begin
                if (done_seen == 0) begin
                    first_k = k;
                    first_v = value_out_o;
                end else begin
                    second_k = k;
                    second_v = value_out_o;
                    start_i  = 1'b0;
                end
                done_seen++;
            end
            if (done_seen < 2) begin
                @(negedge clk);
                k++;
            end
        end
        start_i = 1'b0;
        check_val("hold_first_at", 32'(first_k), 32'd4);
        check_val("hold_first_val", 32'(first_v), 32'd100);
        check_val("hold_second_at", 32'(second_k), 32'd9);
        check_val("hold_second_val", 32'(second_v), 32'd50);
        repeat (6) @(negedge clk);
        check_val("hold_no_third", 32'(busy_o), 32'd0);

        // Reset two cycles into a conversion aborts it and clears the result.
        @(negedge clk);
        start_i     = 1'b1;
        digits_in_i = 16'h1234;
        @(negedge clk);
        start_i = 1'b0;
        @(negedge clk);
        rst_n = 1'b0;
        #1;
        check_val("abort_busy", 32'(busy_o), 32'd0);
        check_val("abort_value", 32'(value_out_o), 32'd0);
        check_val("abort_done", 32'(done_o), 32'd0);
        @(negedge clk);
        rst_n = 1'b1;
        done_seen = 0;
        repeat (6) begin
            @(negedge clk);
            if (done_o) done_seen++;
        end
        check_val("abort_no_done", 32'(done_seen), 32'd0);
        convert("c0042", 16'h0042, 16'h0042, 14'd42, 1'b0);

`ifdef BCD_CHECK_EN
        convert("c12A4", 16'h12A4, 16'h12A4, 14'd0, 1'b1);
        convert("c_after_err", 16'h0042, 16'h0042, 14'd42, 1'b0);
`else
        convert("cF000", 16'hF000, 16'hF000, 14'd15000, 1'b0);
        convert("cFFFF", 16'hFFFF, 16'hFFFF, 14'd281, 1'b0);
`endif

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_bad);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL watchdog: got timeout expected completion");
        $fatal(1, "bench timeout");
    end

endmodule
